// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch PC, synchronous ROM read issue, one-entry skid buffer and sticky HALT.
// One read in flight at most; a stall parks the returning word in the skid so nothing is lost.
module instr_fetch #(
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic [48:0]           imem_rdata,
  output logic                  imem_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [48:0]           instruction,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;
  localparam logic [4:0] OPC_HALT = 5'h1F;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [48:0]           skid_q, skid_d;
  logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [48:0]           instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  instr_valid_q, instr_valid_d;

  logic                  present;
  logic [48:0]           present_word;
  logic [ADDR_WIDTH-1:0] present_pc;

  assign imem_en     = (state_q == S_FETCH) & ~stall & ~branch & ~reset;
  assign imem_addr   = fetch_pc_q;
  assign instruction = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign halted      = (state_q == S_HALTED);

  always_comb begin
    state_d       = (state_q == S_IDLE) ? S_FETCH : state_q;
    fetch_pc_d    = fetch_pc_q;
    pend_d        = pend_q;
    pend_pc_d     = pend_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_d        = skid_q;
    skid_pc_d     = skid_pc_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    instr_valid_d = 1'b0;
    present       = 1'b0;
    present_word  = skid_q;
    present_pc    = skid_pc_q;

    if (state_q == S_HALTED) begin
      state_d = S_HALTED;
    end else if (branch) begin
      // Redirect squashes both the in-flight read and anything parked in the skid.
      fetch_pc_d   = branch_target;
      pend_d       = 1'b0;
      skid_valid_d = 1'b0;
    end else if (stall) begin
      if (pend_q) begin
        skid_d       = imem_rdata;
        skid_pc_d    = pend_pc_q;
        skid_valid_d = 1'b1;
        pend_d       = 1'b0;
      end
    end else begin
      if (skid_valid_q) begin
        present      = 1'b1;
        skid_valid_d = 1'b0;
      end else if (pend_q) begin
        present      = 1'b1;
        present_word = imem_rdata;
        present_pc   = pend_pc_q;
      end

      pend_d = 1'b0;
      if (state_q == S_FETCH) begin
        pend_d     = 1'b1;
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
      end

      if (present) begin
        instr_d       = present_word;
        pc_d          = present_pc;
        instr_valid_d = 1'b1;
        // The read issued alongside a HALT word is dropped here.
        if (present_word[48:44] == OPC_HALT) begin
          state_d = S_HALTED;
          pend_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      pend_q        <= 1'b0;
      pend_pc_q     <= '0;
      skid_valid_q  <= 1'b0;
      skid_q        <= '0;
      skid_pc_q     <= '0;
      instr_q       <= '0;
      pc_q          <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pend_q        <= pend_d;
      pend_pc_q     <= pend_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_q        <= skid_d;
      skid_pc_q     <= skid_pc_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

endmodule
